tilt_to_move: RTL
=================

// Module: tilt_to_move
// PURPOSE
// Turns signed accelerometer tilt samples into the 4-bit one-hot movement pulses consumed by the ball engine.
// Picks the dominant tilt axis and applies a dead-zone. Emits one-cycle step pulses at a rate that rises with tilt
// magnitude. Sits between the accelerometer sample source and the ball engine's movement input.
// PARAMETERS
// CLK_FREQUENCY_HZ       100000000  system clock frequency
// TICK_FREQUENCY_HZ      1000       step-timer tick rate (1 ms)
// SIMULATE               0          1 = prescaler uses SIMULATE_FREQUENCY_CNT
// SIMULATE_FREQUENCY_CNT 5          clocks per tick when SIMULATE=1
// SAMPLE_WIDTH           12         signed accel sample width
// DEADZONE               100        |sample| <= DEADZONE counts as level
// LEVEL_SHIFT            7          (mag-DEADZONE)>>LEVEL_SHIFT gives speed level, clamped to 3
// BASE_PERIOD_TICKS      64         step period at level 0; period = BASE_PERIOD_TICKS>>level
// STALE_TICKS            250        ticks with no sample_valid before forced IDLE
// PORTS
// clk           in   1              system clock
// reset         in   1              asynchronous, active-low reset
// accel_x       in   SAMPLE_WIDTH   signed X tilt; +X = RIGHT
// accel_y       in   SAMPLE_WIDTH   signed Y tilt; +Y = UP
// sample_valid  in   1              1-cycle strobe; accel_x/y valid in this cycle
// movement      out  4              one-hot step pulse: UP=0001 DOWN=0010 LEFT=0100 RIGHT=1000
// tilt_active   out  1              1 while state != IDLE
// speed_level   out  2              current level, 0 when IDLE
// BEHAVIOUR
// - Reset (async, clk-independent): movement=0, tilt_active=0, speed_level=0, state=IDLE, counters=0, latched samples=0.
// - On sample_valid, latch samples. Use |v|; -2^(W-1) saturates to 2^(W-1)-1. Clear the stale counter.
// - Dominant axis: the larger |x| or |y|; a tie goes to X. Direction comes from the sign of the dominant axis.
//   If dominant mag <= DEADZONE, there is no tilt. Direction and level register 1 cycle after sample_valid.
// - States: IDLE -> ARMED on tilt. ARMED -> FIRE when step_cnt >= period. FIRE -> ARMED after 1 cycle.
//   ARMED/FIRE -> IDLE on no-tilt or stale. In IDLE, step_cnt holds 0.
// - step_cnt counts ticks in ARMED only. FIRE drives movement=dir for exactly 1 cycle, then step_cnt clears.
//   First pulse comes one full period after IDLE->ARMED; there is no immediate pulse.
// - Direction or level change while ARMED: step_cnt is kept; the new period and dir apply at the next compare.
//   If a shorter period is already exceeded, FIRE on the next tick.
// - movement is never multi-hot and never asserted outside FIRE. Pulses are >= BASE_PERIOD_TICKS>>3 ticks apart.
//   The ball engine drops pulses arriving while it is busy validating; no ack exists, by design.
// - Stale: STALE_TICKS ticks with no sample_valid -> IDLE, movement=0. The next valid tilt sample re-arms.
// - sample_valid in the FIRE cycle: the pulse completes with the old dir; the new sample applies afterwards.
// - Counter widths are sized by $clog2. Level clamp: level = min(3, (mag-DEADZONE)>>LEVEL_SHIFT).
// STRUCTURE
// - Shared header ball_defs.vh holds the UP/DOWN/LEFT/RIGHT 4-bit localparams.
//   The ball engine includes the same header so the encodings cannot diverge.
// - Sub-module tick_prescaler(clk, reset, tick) derives the 1-cycle tick from CLK_FREQUENCY_HZ/TICK_FREQUENCY_HZ
//   or from SIMULATE_FREQUENCY_CNT.
// - Top level holds the magnitude/axis logic, the FSM and the step/stale counters.
// TESTING (SIMULATE=1, tick every 5 clks)
// - Reset low mid-FIRE -> movement=0 immediately (async), outputs hold reset values until reset=1 and a new tilt sample.
// - x=+300, y=50 held valid -> RIGHT (1000) pulses every 32 ticks (level 1), each 1 clk wide, tilt_active=1.
// - x=-2048, y=0 -> LEFT (0100), level 3, period 8 ticks; abs saturation causes no sign flip.
// - x=200, y=-200 (tie) -> RIGHT; then x=0, y=-900 -> DOWN (0010), keeping step_cnt, level 3.
// - x=100, y=-100 (equal to DEADZONE) -> IDLE, no pulses, speed_level=0; a later x=101 re-arms, first pulse after 64 ticks.
// - One tilt sample, then none -> IDLE after 250 ticks, movement stays 0; check one-hot on every cycle.

Source files
------------

// File: rtl/tilt_to_move_pkg.sv
// Shared encodings for the tilt-to-move block: movement one-hot codes and FSM states.
package tilt_to_move_pkg;

  // One-hot step codes, identical to the ones the ball engine decodes.
  localparam logic [3:0] MOVE_NONE  = 4'b0000;
  localparam logic [3:0] MOVE_UP    = 4'b0001;
  localparam logic [3:0] MOVE_DOWN  = 4'b0010;
  localparam logic [3:0] MOVE_LEFT  = 4'b0100;
  localparam logic [3:0] MOVE_RIGHT = 4'b1000;

  localparam int unsigned MAX_LEVEL = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRE  = 2'd2
  } tilt_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle step-timer tick.
module tick_prescaler #(
  parameter int unsigned CLK_FREQUENCY_HZ       = 100000000,
  parameter int unsigned TICK_FREQUENCY_HZ      = 1000,
  parameter int unsigned SIMULATE               = 0,
  parameter int unsigned SIMULATE_FREQUENCY_CNT = 5
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DIV = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT
                                                : (CLK_FREQUENCY_HZ / TICK_FREQUENCY_HZ);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Free-running divider; tick is registered so it is glitch-free and exactly one clock wide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + ONE;
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/tilt_to_move.sv
// Converts signed accelerometer tilt into rate-controlled one-hot step pulses for the ball engine.
module tilt_to_move
  import tilt_to_move_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY_HZ       = 100000000,
  parameter int unsigned TICK_FREQUENCY_HZ      = 1000,
  parameter int unsigned SIMULATE               = 0,
  parameter int unsigned SIMULATE_FREQUENCY_CNT = 5,
  parameter int unsigned SAMPLE_WIDTH           = 12,
  parameter int unsigned DEADZONE               = 100,
  parameter int unsigned LEVEL_SHIFT            = 7,
  parameter int unsigned BASE_PERIOD_TICKS      = 64,
  parameter int unsigned STALE_TICKS            = 250
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] accel_x,
  input  logic [SAMPLE_WIDTH-1:0] accel_y,
  input  logic                    sample_valid,
  output logic [3:0]              movement,
  output logic                    tilt_active,
  output logic [1:0]              speed_level
);

  localparam int unsigned W       = SAMPLE_WIDTH;
  localparam int unsigned STEP_W  = $clog2(BASE_PERIOD_TICKS + 1);
  localparam int unsigned STALE_W = $clog2(STALE_TICKS + 1);

  localparam logic [W-1:0]       MAG_MAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]       MOST_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]       DZ        = W'(DEADZONE);
  localparam logic [W-1:0]       LVL_CAP   = W'(MAX_LEVEL);
  localparam logic [STEP_W-1:0]  BASE      = STEP_W'(BASE_PERIOD_TICKS);
  localparam logic [STEP_W-1:0]  STEP_ONE  = STEP_W'(1);
  localparam logic [STALE_W-1:0] STALE_LIM = STALE_W'(STALE_TICKS);
  localparam logic [STALE_W-1:0] STALE_ONE = STALE_W'(1);

  // |v| with the most negative code saturating to the largest positive magnitude.
  function automatic logic [W-1:0] abs_sat(input logic [W-1:0] v);
    if (v == MOST_NEG) return MAG_MAX;
    else if (v[W-1])   return W'(-v);
    else               return v;
  endfunction

  logic [W-1:0]       r_x, r_y;
  logic [STALE_W-1:0] r_stale_cnt;
  logic [STEP_W-1:0]  r_step_cnt;
  tilt_state_t        r_state;
  logic [3:0]         r_movement;
  logic               r_tilt_active;
  logic [1:0]         r_speed_level;

  logic               w_tick;
  logic [W-1:0]       w_mag_x, w_mag_y, w_dom_mag, w_excess, w_steps;
  logic               w_x_dom, w_tilt, w_stale;
  logic [3:0]         w_dir;
  logic [1:0]         w_level;
  logic [STEP_W-1:0]  w_period, w_step_next;

  tick_prescaler #(
    .CLK_FREQUENCY_HZ      (CLK_FREQUENCY_HZ),
    .TICK_FREQUENCY_HZ     (TICK_FREQUENCY_HZ),
    .SIMULATE              (SIMULATE),
    .SIMULATE_FREQUENCY_CNT(SIMULATE_FREQUENCY_CNT)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (w_tick)
  );

  // Latch the raw samples; everything downstream is derived from these registers,
  // so direction and level follow one cycle after the strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (sample_valid) begin
      r_x <= accel_x;
      r_y <= accel_y;
    end
  end

  // Dominant axis, dead-zone, direction, speed level and step period from the latched samples.
  always_comb begin
    w_mag_x   = abs_sat(r_x);
    w_mag_y   = abs_sat(r_y);
    w_x_dom   = (w_mag_x >= w_mag_y);
    w_dom_mag = w_x_dom ? w_mag_x : w_mag_y;
    w_tilt    = (w_dom_mag > DZ);
    if (w_x_dom) w_dir = r_x[W-1] ? MOVE_LEFT : MOVE_RIGHT;
    else         w_dir = r_y[W-1] ? MOVE_DOWN : MOVE_UP;
    w_excess    = w_tilt ? (w_dom_mag - DZ) : '0;
    w_steps     = w_excess >> LEVEL_SHIFT;
    w_level     = (w_steps > LVL_CAP) ? 2'(MAX_LEVEL) : w_steps[1:0];
    w_period    = BASE >> w_level;
    w_step_next = r_step_cnt + STEP_ONE;
    w_stale     = (r_stale_cnt == STALE_LIM);
  end

  // Ticks since the last sample strobe, saturating at the stale limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stale_cnt <= '0;
    end else if (sample_valid) begin
      r_stale_cnt <= '0;
    end else if (w_tick && !w_stale) begin
      r_stale_cnt <= r_stale_cnt + STALE_ONE;
    end
  end

  // Step FSM with registered outputs. The compare uses step_cnt+1 on a tick so a
  // pulse lands exactly one period of ticks after arming or after the previous pulse,
  // and an already-exceeded shorter period fires on the very next tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_step_cnt    <= '0;
      r_movement    <= MOVE_NONE;
      r_tilt_active <= 1'b0;
      r_speed_level <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_step_cnt <= '0;
          r_movement <= MOVE_NONE;
          if (w_tilt && !w_stale) begin
            r_state       <= ST_ARMED;
            r_tilt_active <= 1'b1;
            r_speed_level <= w_level;
          end
        end
        ST_ARMED: begin
          if (!w_tilt || w_stale) begin
            r_state       <= ST_IDLE;
            r_step_cnt    <= '0;
            r_movement    <= MOVE_NONE;
            r_tilt_active <= 1'b0;
            r_speed_level <= 2'd0;
          end else begin
            r_speed_level <= w_level;
            if (w_tick) begin
              if (w_step_next >= w_period) begin
                r_state    <= ST_FIRE;
                r_movement <= w_dir;
                r_step_cnt <= '0;
              end else begin
                r_step_cnt <= w_step_next;
              end
            end
          end
        end
        ST_FIRE: begin
          r_movement <= MOVE_NONE;
          r_step_cnt <= '0;
          if (!w_tilt || w_stale) begin
            r_state       <= ST_IDLE;
            r_tilt_active <= 1'b0;
            r_speed_level <= 2'd0;
          end else begin
            r_state       <= ST_ARMED;
            r_speed_level <= w_level;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_step_cnt    <= '0;
          r_movement    <= MOVE_NONE;
          r_tilt_active <= 1'b0;
          r_speed_level <= 2'd0;
        end
      endcase
    end
  end

  assign movement    = r_movement;
  assign tilt_active = r_tilt_active;
  assign speed_level = r_speed_level;

endmodule
